// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Avalon-MM-style read/write bus between a fetch master and mem_responder.
//
// Signals:
//   address       master -> slave  word address for a read or write
//   read          master -> slave  read request
//   write         master -> slave  write request
//   writedata     master -> slave  data for a write
//   readdata      slave  -> master returned read data
//   readdatavalid slave  -> master readdata is valid this cycle
//   waitrequest   slave  -> master request not accepted, master must hold it
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic                  write;
    logic [DATA_WIDTH-1:0] writedata;
    logic [DATA_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Slave-side memory model for the fetch path. Holds a small word-addressed RAM,
// accepts pipelined reads and single-cycle writes, returns read data a fixed
// READ_LATENCY cycles after acceptance and throttles the master with
// waitrequest once MAX_PENDING reads are outstanding.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (restores mem[i] = i, flushes reads)
//   bus  mem_responder_if.slave (address/read/write/writedata in,
//        readdata/readdatavalid/waitrequest out)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 16,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    localparam int IDX_W  = $clog2(DEPTH);
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    // When MAX_PENDING equals the pipeline depth, the pipeline itself already
    // bounds occupancy, so the slot of a read completing this cycle can be
    // handed straight to a new read and back-to-back reads never stall.
    localparam bit SLOT_REUSE = (MAX_PENDING == READ_LATENCY);

    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [READ_LATENCY-1:0] r_pipeValid;
    logic [DATA_WIDTH-1:0]   r_pipeData [READ_LATENCY];
    logic [PEND_W-1:0]       r_pending;

    logic [IDX_W-1:0] w_idx;
    logic             w_stall;
    logic             w_readAccept;
    logic             w_writeAccept;
    logic             w_respValid;

    assign w_idx       = bus.address[IDX_W-1:0];
    assign w_respValid = r_pipeValid[READ_LATENCY-1];

    // Stall is a decode of registered state only, never of read/write.
    assign w_stall = (r_pending == PEND_MAX) && !(SLOT_REUSE && w_respValid);

    // A read wins over a simultaneous write; the write is dropped.
    assign w_readAccept  = bus.read && !w_stall;
    assign w_writeAccept = bus.write && !bus.read && !w_stall;

    assign bus.waitrequest   = w_stall;
    assign bus.readdatavalid = w_respValid;
    assign bus.readdata      = r_pipeData[READ_LATENCY-1];

    // Memory, response pipeline and outstanding-read counter.
    // Each data stage only advances when a valid word moves into it, so the
    // last stage keeps the most recent response between valid cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_WIDTH'(i);
            end
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipeData[i] <= '0;
            end
            r_pipeValid <= '0;
            r_pending   <= '0;
        end else begin
            if (w_writeAccept) begin
                r_mem[w_idx] <= bus.writedata;
            end

            r_pipeValid[0] <= w_readAccept;
            if (w_readAccept) begin
                r_pipeData[0] <= r_mem[w_idx];
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipeValid[i] <= r_pipeValid[i-1];
                if (r_pipeValid[i-1]) begin
                    r_pipeData[i] <= r_pipeData[i-1];
                end
            end

            if (w_readAccept && !w_respValid) begin
                r_pending <= r_pending + PEND_W'(1);
            end else if (!w_readAccept && w_respValid) begin
                r_pending <= r_pending - PEND_W'(1);
            end
        end
    end

endmodule
